// File: rtl/k_line_uart.sv
// k_line_uart: byte-oriented 8N1 UART for an ISO 9141 K-line. It sits on the
// SPI-slave register bus next to version_string and led_control.
//
// Register map (offset from BaseAddress):
//   +0 STATUS  R   [0] tx_full [1] tx_empty [2] rx_valid [3] rx_overrun
//                  [4] framing_err [5] tx_busy [12:8] tx_count
//   +1 TX_DATA W   push data_i[7:0] into the TX FIFO (reads return 0)
//   +2 RX_DATA R   [7:0] rx_byte [8] rx_valid
//              W   [0] clear rx_valid [1] clear rx_overrun [2] clear framing_err
//   +3 CTRL    R/W [0] echo_suppress (reset 1) [1] tx_break
//
// Ports:
//   clk_i        system clock
//   reset_i      synchronous, active-high reset
//   address_i    bus address
//   data_i       bus write data
//   rd_wr_i      1 = single-cycle write strobe, 0 = read
//   data_o       combinational read data, '0 outside the 4-address window
//   k_line_tx_o  K-line transmit, idle high
//   k_line_rx_i  K-line receive, asynchronous, idle high
module k_line_uart #(
    parameter int FPGAClkSpeed  = 50000000,
    parameter int BaudRate      = 10400,
    parameter int BaseAddress   = 'h1300,
    parameter int address_width = 15,
    parameter int data_width    = 16,
    parameter int TxFifoDepth   = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [data_width-1:0]    data_o,
    output logic                     k_line_tx_o,
    input  logic                     k_line_rx_i
);
    localparam int ClksPerBit = FPGAClkSpeed / BaudRate;
    localparam int HalfBit    = ClksPerBit / 2;
    localparam int CW         = $clog2(ClksPerBit);
    localparam int PW         = $clog2(TxFifoDepth);

    localparam logic [CW-1:0]            BIT_END   = CW'(ClksPerBit - 1);
    localparam logic [CW-1:0]            MID_END   = CW'(HalfBit - 1);
    localparam logic [PW:0]              FIFO_FULL = (PW+1)'(TxFifoDepth);
    localparam logic [address_width-1:0] BASE      = address_width'(BaseAddress);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       hit;
        logic [1:0] reg_sel;
        logic       wr;
    } bus_req_t;

    logic [address_width-1:0] offs;
    bus_req_t                 req;
    logic                     wr_tx, wr_rx, wr_ctrl;

    // Unsigned subtraction: addresses below BASE wrap to large offsets and miss.
    assign offs = address_i - BASE;

    always_comb begin
        req.hit     = (offs[address_width-1:2] == '0);
        req.reg_sel = offs[1:0];
        req.wr      = rd_wr_i & req.hit;
    end

    assign wr_tx   = req.wr && (req.reg_sel == 2'd1);
    assign wr_rx   = req.wr && (req.reg_sel == 2'd2);
    assign wr_ctrl = req.wr && (req.reg_sel == 2'd3);

    logic unused_data;
    assign unused_data = ^data_i[data_width-1:8];

    // ------------------------------------------------------------------
    // CTRL
    // ------------------------------------------------------------------
    logic echo_suppress, tx_break;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            echo_suppress <= 1'b1;
            tx_break      <= 1'b0;
        end else if (wr_ctrl) begin
            echo_suppress <= data_i[0];
            tx_break      <= data_i[1];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [TxFifoDepth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_count == FIFO_FULL);
    assign tx_empty = (tx_count == '0);
    // A full FIFO drops the write even if the TX FSM pops in the same cycle.
    assign tx_push  = wr_tx && !tx_full;

    always_ff @(posedge clk_i) begin
        if (tx_push) fifo_mem[wr_ptr] <= data_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_sh;
    logic          tx_bit_end, tx_busy;

    assign tx_bit_end = (tx_cnt == BIT_END);
    assign tx_busy    = (tx_state != TX_IDLE);
    // Pop from IDLE, or straight out of the last STOP cycle for back-to-back frames.
    assign tx_pop     = !tx_empty && !tx_break &&
                        ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_sh       <= '0;
            k_line_tx_o <= 1'b1;
        end else if (tx_break) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            k_line_tx_o <= 1'b0;
        end else if (tx_pop) begin
            tx_state    <= TX_START;
            tx_cnt      <= '0;
            tx_sh       <= fifo_mem[rd_ptr];
            k_line_tx_o <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx_cnt      <= '0;
                    k_line_tx_o <= 1'b1;
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt      <= '0;
                        tx_bit      <= '0;
                        tx_state    <= TX_DATA;
                        k_line_tx_o <= tx_sh[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        tx_sh  <= {1'b0, tx_sh[7:1]};
                        if (tx_bit == 3'd7) begin
                            tx_state    <= TX_STOP;
                            k_line_tx_o <= 1'b1;
                        end else begin
                            tx_bit      <= tx_bit + 1'b1;
                            k_line_tx_o <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt      <= '0;
                        tx_state    <= TX_IDLE;
                        k_line_tx_o <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser: [1:0] two-flop sync, [2] previous synced sample
    // ------------------------------------------------------------------
    logic [2:0] rx_pipe;
    logic       rx_s, rx_fall;

    always_ff @(posedge clk_i) begin
        if (reset_i) rx_pipe <= '1;
        else         rx_pipe <= {rx_pipe[1:0], k_line_rx_i};
    end

    assign rx_s    = rx_pipe[1];
    assign rx_fall = rx_pipe[2] & ~rx_pipe[1];

    // ------------------------------------------------------------------
    // RX FSM and flags. Clears are written first so a same-cycle set wins.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HI} rx_state_t;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh, rx_byte;
    logic          rx_echo, rx_valid, rx_overrun, framing_err;
    logic          rx_bit_end;

    assign rx_bit_end = (rx_cnt == BIT_END);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_sh       <= '0;
            rx_byte     <= '0;
            rx_echo     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (wr_rx) begin
                if (data_i[0]) rx_valid    <= 1'b0;
                if (data_i[1]) rx_overrun  <= 1'b0;
                if (data_i[2]) framing_err <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) begin
                        rx_state <= RX_START;
                        // Frames starting while we drive the line are our own echo.
                        rx_echo  <= echo_suppress && (tx_busy || tx_break);
                    end
                end
                RX_START: begin
                    if (rx_cnt == MID_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                            if (!rx_echo) begin
                                if (rx_valid) begin
                                    rx_overrun <= 1'b1;
                                end else begin
                                    rx_byte  <= rx_sh;
                                    rx_valid <= 1'b1;
                                end
                            end
                        end else begin
                            rx_state <= RX_WAIT_HI;
                            if (!rx_echo) framing_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HI: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        data_o = '0;
        if (req.hit) begin
            case (req.reg_sel)
                2'd0: begin
                    data_o[0]         = tx_full;
                    data_o[1]         = tx_empty;
                    data_o[2]         = rx_valid;
                    data_o[3]         = rx_overrun;
                    data_o[4]         = framing_err;
                    data_o[5]         = tx_busy;
                    data_o[8 +: PW+1] = tx_count;
                end
                2'd2: begin
                    data_o[7:0] = rx_byte;
                    data_o[8]   = rx_valid;
                end
                2'd3: begin
                    data_o[0] = echo_suppress;
                    data_o[1] = tx_break;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_k_line_uart.sv
module tb_k_line_uart;
    localparam int C = 10;  // clocks per bit for the bench parameters
    localparam logic [14:0] A_STAT = 15'h1300;
    localparam logic [14:0] A_TX   = 15'h1301;
    localparam logic [14:0] A_RX   = 15'h1302;
    localparam logic [14:0] A_CTRL = 15'h1303;

    logic        clk = 1'b0;
    logic        reset, rd_wr, tx, rx, rx_drv, loop;
    logic [14:0] address;
    logic [15:0] data_in, data_out;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    k_line_uart #(
        .FPGAClkSpeed(1000000), .BaudRate(100000), .BaseAddress('h1300),
        .address_width(15), .data_width(16), .TxFifoDepth(16)
    ) dut (
        .clk_i(clk), .reset_i(reset), .address_i(address), .data_i(data_in),
        .rd_wr_i(rd_wr), .data_o(data_out), .k_line_tx_o(tx), .k_line_rx_i(rx)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [14:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a; data_in = d; rd_wr = 1'b1;
        @(negedge clk);
        rd_wr = 1'b0; address = A_STAT;
    endtask

    task automatic bus_rd(input logic [14:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        #1 d = data_out;
        address = A_STAT;
    endtask

    // Returns on the first negedge where tx is low (offset 0 of a start bit).
    task automatic wait_fall(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Mid-bit sampling of one frame. gap = negedges waited for the start edge;
    // returns at the stop-bit sample point (offset 94).
    task automatic get_frame(input bit aligned, output logic [7:0] b, output int gap);
        b = '0; gap = 0;
        if (aligned) @(negedge clk);
        else do begin @(negedge clk); gap++; end while (tx !== 1'b0 && gap < 300);
        repeat (4) @(negedge clk);
        chk("frame_start", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clk);
            b[i] = tx;
        end
        repeat (C) @(negedge clk);
        chk("frame_stop", tx, 1'b1);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (C) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (2*C) @(negedge clk);
    endtask

    // Receiver reference: flags and holding register as seen by software.
    logic       m_valid, m_ovr, m_ferr;
    logic [7:0] m_byte;

    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (!stop)        m_ferr = 1'b1;
        else if (m_valid) m_ovr  = 1'b1;
        else begin
            m_valid = 1'b1;
            m_byte  = b;
        end
    endtask

    task automatic model_clear(input logic [2:0] c);
        if (c[0]) m_valid = 1'b0;
        if (c[1]) m_ovr   = 1'b0;
        if (c[2]) m_ferr  = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        logic [15:0] d;
        bus_rd(A_RX, d);
        chk({tag, "_rxdata"}, d, {7'd0, m_valid, m_byte});
        bus_rd(A_STAT, d);
        chk({tag, "_status"}, d, {11'd0, m_ferr, m_ovr, m_valid, 2'b10});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        logic [9:0]  exp_bits;
        logic [7:0]  exp_q[$];
        int          gap, errs, berr;
        bit          seen;

        reset = 1'b1; rd_wr = 1'b0; address = A_STAT; data_in = '0;
        rx_drv = 1'b1; loop = 1'b0;
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;
        repeat (3) @(negedge clk);
        chk("reset_tx_during", tx, 1'b1);
        reset = 1'b0;

        // ---- reset state and address window
        bus_rd(A_STAT, d);     chk("reset_status", d, 16'h0002);
        bus_rd(A_CTRL, d);     chk("reset_ctrl", d, 16'h0001);
        bus_rd(A_RX, d);       chk("reset_rxdata", d, 16'h0000);
        bus_rd(A_TX, d);       chk("txdata_read", d, 16'h0000);
        bus_rd(15'h1304, d);   chk("above_window", d, 16'h0000);
        bus_rd(15'h12FF, d);   chk("below_window", d, 16'h0000);
        chk("reset_tx", tx, 1'b1);

        // ---- single byte 'hA5: exact waveform, cycle by cycle
        bus_wr(A_TX, 16'h00A5);
        wait_fall(20, seen);
        chk("a5_start_seen", seen, 1'b1);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        errs = 0; berr = 0;
        for (int k = 0; k < 100; k++) begin
            if (tx !== exp_bits[k/10]) errs++;
            if (data_out[5] !== 1'b1) berr++;
            @(negedge clk);
        end
        chk("a5_wave_errs", errs, 0);
        chk("a5_busy_errs", berr, 0);
        chk("a5_idle_tx", tx, 1'b1);
        bus_rd(A_STAT, d);     chk("a5_status_done", d, 16'h0002);

        // ---- fill FIFO under break, 17th push dropped
        bus_wr(A_CTRL, 16'h0003);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            bus_wr(A_TX, {8'd0, b});
            if (i < 16) exp_q.push_back(b);
        end
        bus_rd(A_STAT, d);     chk("full_status", d, 16'h1001);
        chk("break_tx_low", tx, 1'b0);
        bus_rd(A_CTRL, d);     chk("break_ctrl", d, 16'h0003);
        bus_wr(A_CTRL, 16'h0001);
        for (int i = 0; i < 16; i++) begin
            get_frame(i == 0, b, gap);
            chk($sformatf("fifo_frame%0d", i), b, exp_q.pop_front());
            if (i > 0) chk($sformatf("fifo_gap%0d", i), gap, 6);
        end
        wait_fall(40, seen);
        chk("no_17th_frame", seen, 1'b0);
        bus_rd(A_STAT, d);     chk("drained_status", d, 16'h0002);

        // ---- external RX, echo suppression off
        bus_wr(A_CTRL, 16'h0000);
        send_rx(8'h3C, 1'b1);  model_frame(8'h3C, 1'b1);
        bus_rd(A_RX, d);       chk("rx_3c", d, 16'h013C);
        send_rx(8'h55, 1'b1);  model_frame(8'h55, 1'b1);
        bus_rd(A_RX, d);       chk("rx_kept_3c", d, 16'h013C);
        bus_rd(A_STAT, d);     chk("rx_overrun_bit", d[3], 1'b1);
        bus_wr(A_RX, 16'h0003); model_clear(3'b011);
        bus_rd(A_STAT, d);     chk("rx_cleared", d[3:2], 2'b00);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            bit         stop;
            c    = 3'($urandom_range(0, 7));
            bus_wr(A_RX, {13'd0, c}); model_clear(c);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_rx(b, stop);      model_frame(b, stop);
            check_rx($sformatf("rand%0d", i));
        end

        // ---- framing error, then a short glitch must change nothing
        bus_wr(A_RX, 16'h0007); model_clear(3'b111);
        send_rx(8'($urandom), 1'b0); model_frame(8'h00, 1'b0);
        check_rx("framing");
        rx_drv = 1'b0; repeat (3) @(negedge clk);
        rx_drv = 1'b1; repeat (30) @(negedge clk);
        check_rx("glitch");

        // ---- loopback: own echo suppressed, then received with suppression off
        bus_wr(A_RX, 16'h0007); model_clear(3'b111);
        loop = 1'b1;
        bus_wr(A_CTRL, 16'h0001);
        bus_wr(A_TX, 16'h0081);
        get_frame(1'b0, b, gap);
        chk("echo_tx_byte", b, 8'h81);
        repeat (20) @(negedge clk);
        bus_rd(A_STAT, d);     chk("echo_suppressed", d, 16'h0002);
        bus_wr(A_CTRL, 16'h0000);
        b = 8'($urandom);
        bus_wr(A_TX, {8'd0, b});
        exp_bits[7:0] = b;
        get_frame(1'b0, b, gap);
        chk("loop_tx_byte", b, exp_bits[7:0]);
        repeat (20) @(negedge clk);
        bus_rd(A_RX, d);       chk("loop_rx_byte", d, {8'h01, exp_bits[7:0]});

        // ---- reset mid-DATA of an all-zero byte
        bus_wr(A_TX, 16'h0000);
        wait_fall(20, seen);
        chk("rst_frame_seen", seen, 1'b1);
        repeat (30) @(negedge clk);
        chk("rst_pre_low", tx, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_high", tx, 1'b1);
        reset = 1'b0;
        bus_rd(A_STAT, d);     chk("rst_status", d, 16'h0002);
        bus_rd(A_CTRL, d);     chk("rst_ctrl", d, 16'h0001);
        repeat (20) @(negedge clk);
        chk("rst_tx_idle", tx, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
